// File: rtl/envia_medida_serial_pkg.sv
// Shared constants, state encodings and frame helpers for the sonar measurement serial sender.
// Optional feature: define ENVIA_MEDIDA_PARIDADE_EN to add an odd parity bit (7O2 instead of 7N2).
package envia_medida_serial_pkg;

  localparam logic [3:0] DB_INICIAL     = 4'b0000;
  localparam logic [3:0] DB_PREPARACAO  = 4'b0001;
  localparam logic [3:0] DB_TRANSMITE   = 4'b0010;
  localparam logic [3:0] DB_ESPERA      = 4'b0011;
  localparam logic [3:0] DB_PROXIMO     = 4'b0100;
  localparam logic [3:0] DB_FINAL_ENVIO = 4'b1111;
  localparam logic [3:0] DB_ILEGAL      = 4'b1110;

  typedef enum logic [3:0] {
    INICIAL     = DB_INICIAL,
    PREPARACAO  = DB_PREPARACAO,
    TRANSMITE   = DB_TRANSMITE,
    ESPERA      = DB_ESPERA,
    PROXIMO     = DB_PROXIMO,
    FINAL_ENVIO = DB_FINAL_ENVIO
  } estado_t;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_HASH = 7'h23;
  localparam int         MSG_LEN    = 4;

`ifdef ENVIA_MEDIDA_PARIDADE_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Digits above 9 deliberately map to 0x3A-0x3F.
  function automatic logic [6:0] ascii_digito(input logic [3:0] n);
    return ASCII_ZERO + {3'b000, n};
  endfunction

  function automatic logic paridade_impar(input logic [6:0] d);
    return ~(^d);
  endfunction

  // Bit 0 is sent first: start, data LSB first, optional parity, two stops.
  function automatic logic [FRAME_BITS-1:0] monta_quadro(input logic [6:0] d);
`ifdef ENVIA_MEDIDA_PARIDADE_EN
    return {2'b11, paridade_impar(d), d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

endpackage

// File: rtl/envia_medida_serial_tx.sv
// Serial transmitter for one 7-bit character; fim is high during the last cycle of the last stop bit.
// Frame length depends on ENVIA_MEDIDA_PARIDADE_EN (see package).
module tx_serial_7bits
  import envia_medida_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados,
  output logic       saida_serial,
  output logic       fim
);

  localparam logic [11:0] ULTIMO_CLK = 12'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  ULTIMO_BIT = 4'(FRAME_BITS - 1);

  logic                  ocupado_tx;
  logic [11:0]           conta_clk;
  logic [3:0]            conta_bit;
  logic [FRAME_BITS-1:0] quadro;

  // quadro[0] always holds the bit currently on the line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ocupado_tx   <= 1'b0;
      conta_clk    <= '0;
      conta_bit    <= '0;
      quadro       <= '1;
      saida_serial <= 1'b1;
    end else if (!ocupado_tx) begin
      if (partida) begin
        quadro       <= monta_quadro(dados);
        saida_serial <= 1'b0;
        ocupado_tx   <= 1'b1;
        conta_clk    <= '0;
        conta_bit    <= '0;
      end
    end else if (conta_clk == ULTIMO_CLK) begin
      conta_clk <= '0;
      if (conta_bit == ULTIMO_BIT) begin
        ocupado_tx   <= 1'b0;
        conta_bit    <= '0;
        saida_serial <= 1'b1;
      end else begin
        conta_bit    <= conta_bit + 4'd1;
        quadro       <= {1'b1, quadro[FRAME_BITS-1:1]};
        saida_serial <= quadro[1];
      end
    end else begin
      conta_clk <= conta_clk + 12'd1;
    end
  end

  // Announcing completion one cycle early keeps the inter-character gap at two cycles.
  assign fim = ocupado_tx && (conta_clk == ULTIMO_CLK) && (conta_bit == ULTIMO_BIT);

endmodule

// File: rtl/envia_medida_serial.sv
// Sends a latched 3-digit BCD measurement as "HTU#" over a 7-bit async serial line.
// Parity is enabled by defining ENVIA_MEDIDA_PARIDADE_EN.
module envia_medida_serial
  import envia_medida_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enviar,
  input  logic [11:0] medida,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam logic [1:0] ULTIMO_INDICE = 2'(MSG_LEN - 1);

  estado_t     estado, proximo_estado;
  logic [11:0] medida_reg;
  logic [1:0]  indice;
  logic [6:0]  caractere;
  logic        partida;
  logic        fim;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo_estado;
  end

  always_comb begin
    proximo_estado = estado;
    partida        = 1'b0;
    ocupado        = 1'b1;
    pronto         = 1'b0;
    db_estado      = estado;
    case (estado)
      INICIAL: begin
        ocupado = 1'b0;
        if (enviar) proximo_estado = PREPARACAO;
      end
      PREPARACAO: proximo_estado = TRANSMITE;
      TRANSMITE: begin
        partida        = 1'b1;
        proximo_estado = ESPERA;
      end
      ESPERA: begin
        if (fim) proximo_estado = (indice == ULTIMO_INDICE) ? FINAL_ENVIO : PROXIMO;
      end
      PROXIMO: proximo_estado = TRANSMITE;
      FINAL_ENVIO: begin
        pronto         = 1'b1;
        proximo_estado = INICIAL;
      end
      default: begin
        db_estado      = DB_ILEGAL;
        proximo_estado = INICIAL;
      end
    endcase
  end

  // The measurement is frozen for the whole message once preparacao passes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      medida_reg <= '0;
      indice     <= '0;
    end else if (estado == PREPARACAO) begin
      medida_reg <= medida;
      indice     <= '0;
    end else if (estado == PROXIMO) begin
      indice <= indice + 2'd1;
    end
  end

  always_comb begin
    caractere = ASCII_HASH;
    case (indice)
      2'd0:    caractere = ascii_digito(medida_reg[11:8]);
      2'd1:    caractere = ascii_digito(medida_reg[7:4]);
      2'd2:    caractere = ascii_digito(medida_reg[3:0]);
      default: caractere = ASCII_HASH;
    endcase
  end

  tx_serial_7bits #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clock       (clock),
    .reset       (reset),
    .partida     (partida),
    .dados       (caractere),
    .saida_serial(saida_serial),
    .fim         (fim)
  );

endmodule

// File: tb/tb_envia_medida_serial.sv
// Directed bench for envia_medida_serial with CLKS_PER_BIT=4; line sampled on falling edges.
module tb_envia_medida_serial;

  localparam int C = 4;
`ifdef ENVIA_MEDIDA_PARIDADE_EN
  localparam int FB = 11;
  localparam logic [FB-1:0] FRAME_31 = 11'b11001100010;
`else
  localparam int FB = 10;
  localparam logic [FB-1:0] FRAME_31 = 10'b1101100010;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enviar = 1'b0;
  logic [11:0] medida = 12'h000;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;
  logic [3:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;
  logic [FB-1:0] frame0;

  envia_medida_serial #(.CLKS_PER_BIT(C)) dut (
    .clock       (clock),
    .reset       (reset),
    .enviar      (enviar),
    .medida      (medida),
    .saida_serial(saida_serial),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (pronto === 1'b1) pronto_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FB-1:0] frame_of(input logic [6:0] ch);
`ifdef ENVIA_MEDIDA_PARIDADE_EN
    return {2'b11, ~(^ch), ch, 1'b0};
`else
    return {2'b11, ch, 1'b0};
`endif
  endfunction

  task automatic pulse_enviar();
    @(negedge clock);
    enviar = 1'b1;
    @(negedge clock);
    enviar = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int idle);
    bit found;
    found = 0;
    idle = 0;
    while (!found && idle < 100) begin
      @(negedge clock);
      if (saida_serial === 1'b0) found = 1;
      else idle++;
    end
    if (!found) chk({tag, "_start_timeout"}, 64'd0, 64'd1);
  endtask

  // Called on the first low sample; captures every cycle of the frame.
  task automatic get_frame(input logic [6:0] ch, input string tag, output logic [FB-1:0] mid);
    logic [63:0]   got;
    logic [63:0]   expv;
    logic [FB-1:0] fb;
    got = '0;
    expv = '0;
    mid = '0;
    fb = frame_of(ch);
    for (int i = 0; i < FB * C; i++) begin
      if (i > 0) @(negedge clock);
      got[i]  = saida_serial;
      expv[i] = fb[i / C];
      if (i % C == C / 2) mid[i / C] = saida_serial;
    end
    chk(tag, got, expv);
  endtask

  task automatic run_message(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                             input logic [6:0] c3, input int first_idle, input string tag);
    logic [6:0]    cs[4];
    logic [FB-1:0] mid;
    int            idle;
    int            p0;
    cs = '{c0, c1, c2, c3};
    p0 = pronto_cnt;
    for (int j = 0; j < 4; j++) begin
      wait_start($sformatf("%s_c%0d", tag, j), idle);
      chk($sformatf("%s_gap%0d", tag, j), 64'(idle), 64'((j == 0) ? first_idle : 2));
      get_frame(cs[j], $sformatf("%s_frame%0d", tag, j), mid);
      if (j == 0) frame0 = mid;
    end
    @(negedge clock);
    chk({tag, "_pronto_hi"}, 64'(pronto), 64'd1);
    chk({tag, "_db_final"}, 64'(db_estado), 64'hF);
    @(negedge clock);
    chk({tag, "_pronto_lo"}, 64'(pronto), 64'd0);
    chk({tag, "_db_inicial"}, 64'(db_estado), 64'h0);
    chk({tag, "_pronto_count"}, 64'(pronto_cnt - p0), 64'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int lows;
    int busy;
    lows = 0;
    busy = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (saida_serial !== 1'b1) lows++;
      if (ocupado !== 1'b0) busy++;
    end
    chk({tag, "_line_low_cycles"}, 64'(lows), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int idle;
    logic [FB-1:0] mid;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_line", 64'(saida_serial), 64'd1);
    chk("rst_ocupado", 64'(ocupado), 64'd0);
    chk("rst_pronto", 64'(pronto), 64'd0);
    chk("rst_db", 64'(db_estado), 64'h0);
    reset = 1'b0;
    @(negedge clock);

    // Basic message "123#"
    medida = 12'h123;
    pulse_enviar();
    run_message(7'h31, 7'h32, 7'h33, 7'h23, 1, "m123");
    chk("frame_31_bits", 64'(frame0), 64'(FRAME_31));
    chk("idle_ocupado", 64'(ocupado), 64'd0);

    // Input changes and a second request during transmission are ignored
    medida = 12'h123;
    pulse_enviar();
    fork
      run_message(7'h31, 7'h32, 7'h33, 7'h23, 1, "mfreeze");
      begin
        repeat (30) @(negedge clock);
        medida = 12'h999;
        enviar = 1'b1;
        @(negedge clock);
        enviar = 1'b0;
      end
    join
    expect_quiet("no_second", 80);

    // Hex nibbles above 9
    medida = 12'hAF0;
    pulse_enviar();
    run_message(7'h3A, 7'h3F, 7'h30, 7'h23, 1, "mAF0");

    // Reset during tens-digit data bits
    medida = 12'h123;
    pulse_enviar();
    wait_start("rst_c0", idle);
    get_frame(7'h31, "rst_frame0", mid);
    wait_start("rst_c1", idle);
    repeat (3 * C) @(negedge clock);
    chk("rst_mid_line_before", 64'(saida_serial), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_line", 64'(saida_serial), 64'd1);
    chk("rst_mid_db", 64'(db_estado), 64'h0);
    chk("rst_mid_ocupado", 64'(ocupado), 64'd0);
    chk("rst_mid_pronto", 64'(pronto), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    expect_quiet("after_rst", 80);
    pulse_enviar();
    run_message(7'h31, 7'h32, 7'h33, 7'h23, 1, "m_after_rst");

    // enviar held high: back-to-back messages
    medida = 12'h450;
    @(negedge clock);
    enviar = 1'b1;
    run_message(7'h34, 7'h35, 7'h30, 7'h23, 2, "held1");
    run_message(7'h34, 7'h35, 7'h30, 7'h23, 2, "held2");
    enviar = 1'b0;
    expect_quiet("held_end", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/envia_medida_serial.md
ENVIA_MEDIDA_SERIAL -- requirements
Module: envia_medida_serial

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..4095.
REQ-002 SHALL have port: clock  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: enviar  input  1  start request, sampled only in state inicial.
REQ-005 SHALL have port: medida  input  12  three BCD digits from the sonar interface: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 SHALL have port: saida_serial  output  1  asynchronous serial line, idle high.
REQ-007 SHALL have port: ocupado  output  1  high in every state except inicial.
REQ-008 SHALL have port: pronto  output  1  one-cycle pulse when the whole message has been sent.
REQ-009 SHALL have port: db_estado  output  4  debug state code.

Function
REQ-010 SHALL transmit, per request, the 4-character message: hundreds, tens, units, '#' (0x23), in that order.
REQ-011 SHALL encode each digit nibble n as 7-bit ASCII 0x30+n; nibbles A-F SHALL yield 0x3A-0x3F with no saturation or error flag.
REQ-012 SHALL send each character as frame: start bit 0, 7 data bits LSB first, parity bit (REQ-030), 2 stop bits 1; each bit exactly CLKS_PER_BIT cycles.
REQ-013 SHALL implement states with db_estado codes: inicial 0000, preparacao 0001, transmite 0010, espera 0011, proximo 0100, final_envio 1111; any illegal encoding SHALL show 1110 and go to inicial next cycle.
REQ-014 SHALL transition inicial -> preparacao when enviar=1 at a clock edge, else remain.
REQ-015 SHALL, in preparacao (one cycle), latch medida into an internal register and clear the character index to 0; later changes on medida SHALL not affect the message.
REQ-016 SHALL, in transmite (one cycle), pulse partida to the transmitter sub-module for the indexed character, then go to espera.
REQ-017 SHALL drive the start bit on saida_serial on the clock edge following transmite.
REQ-018 SHALL stay in espera until the sub-module signals fim; then go to proximo if index<3, else final_envio.
REQ-019 SHALL, in proximo (one cycle), increment index and return to transmite; inter-character gap SHALL be exactly 2 idle-high cycles.
REQ-020 SHALL assert pronto only in final_envio (exactly one cycle), then return to inicial.
REQ-021 SHALL ignore enviar in all states except inicial; enviar held high continuously SHALL start a new message 1 cycle after each pronto.

Reset
REQ-022 SHALL, on reset at any time including mid-frame, immediately force: state inicial, saida_serial=1, ocupado=0, pronto=0, db_estado=0000, index=0, bit counters=0.
REQ-023 SHALL resume normal operation on the first clock edge after reset deasserts, with no partial frame completed.

Configuration
REQ-030 SHALL, when macro ENVIA_MEDIDA_PARIDADE_EN is defined, insert an odd parity bit (data bits + parity have odd number of ones) giving an 11-bit frame; when undefined, omit the parity bit giving a 10-bit frame (7N2) with all other timing unchanged.

Structure
REQ-040 SHALL place state encodings, db_estado codes, ASCII constants (0x30, 0x23) and message length 4 in a shared package.
REQ-041 SHALL use one sub-module tx_serial_7bits (ports clock, reset, partida, dados[6:0], saida_serial, fim) containing bit timing, shift register and parity; top level holds FSM, index and medida register.

Verification (CLKS_PER_BIT=4)
REQ-050 SHALL check: medida=0x123, enviar pulse -> characters 0x31,0x32,0x33,0x23 on line, pronto once, 1 cycle after final stop bit.
REQ-051 SHALL check: with parity enabled, 0x31 frame = 0,1000110,0,1,1 (44 cycles); with macro undefined, same frame without parity bit (40 cycles).
REQ-052 SHALL check: medida changed to 0x999 and enviar re-pulsed during transmission -> message still "123#", no second message started.
REQ-053 SHALL check: reset asserted during tens-digit data bits -> saida_serial=1, db_estado=0000 same cycle; next enviar sends full message from hundreds.
REQ-054 SHALL check: medida=0xAF0 -> characters 0x3A,0x3F,0x30,0x23.
REQ-055 SHALL check: enviar held high -> back-to-back messages, 1 cycle of inicial plus preparacao between pronto and next start bit.
